// File: rtl/shift_deser.sv
// shift_deser: serial-to-parallel deserializer with a valid/ready output
// handshake and a sticky overrun flag.
//
// Bits are sampled on clk_i when shift_i is high. Once a full frame has been
// collected, the word is presented on dout_o with dout_valid_o. If the
// previous word has not been consumed by then, the new word is dropped and
// overrun_o is set.
//
// Optional feature: define SHIFT_DESER_PARITY_EN to add one trailing
// even-parity bit per frame and a parity_err_o output. Without the macro,
// a frame is exactly WIDTH data bits and parity_err_o does not exist.
//
// All state uses a synchronous, active-high reset (reset_i).

module shift_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sin_i,
  input  logic             shift_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic             overrun_o,
`ifdef SHIFT_DESER_PARITY_EN
  output logic             parity_err_o,
`endif
  input  logic             clear_ovr_i
);

  // Frame length in serial bits. The parity variant carries one extra bit
  // after the data bits.
`ifdef SHIFT_DESER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  // The counter must be able to hold FRAME_LEN-1.
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  // Receive FSM: IDLE means no bits of a frame have arrived yet. ACTIVE
  // means a frame is partly received.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] sreg_shifted;

  logic             accept_bit;
  logic             frame_done;
  logic [WIDTH-1:0] word_assembled;
  logic             transfer;
  logic             load_word;
  logic             drop_word;

`ifdef SHIFT_DESER_PARITY_EN
  logic             parity_err_q;
  logic             parity_calc;
`endif

  // A bit is taken only when shift_i is high. clear_i has priority, so the
  // bit offered on a clearing edge is dropped.
  assign accept_bit = shift_i & ~clear_i;
  assign frame_done = accept_bit & (cnt_q == CNT_LAST);

  // Shift one new bit into the register. The shift direction decides
  // whether the first bit ends up in the MSB or the LSB.
  always_comb begin
    sreg_shifted = sreg_q;
    if (MSB_FIRST) begin
      sreg_shifted = {sreg_q[WIDTH-2:0], sin_i};
    end else begin
      sreg_shifted = {sin_i, sreg_q[WIDTH-1:1]};
    end
  end

  // Pick the word to publish when a frame completes. In the parity variant
  // the data is already in the register and the last bit is the parity bit.
`ifdef SHIFT_DESER_PARITY_EN
  assign word_assembled = sreg_q;
  assign parity_calc    = (^sreg_q) ^ sin_i;
`else
  assign word_assembled = sreg_shifted;
`endif

  // Output handshake. ready is ignored unless a word is held. A completed
  // word is loaded if the slot is empty or is being emptied on this edge.
  // Otherwise it is dropped.
  assign transfer  = dout_valid_o & dout_ready_i;
  assign load_word = frame_done & (~dout_valid_o | dout_ready_i);
  assign drop_word = frame_done & dout_valid_o & ~dout_ready_i;

  // Next state for the receive FSM, the counter and the shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    if (clear_i) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
      sreg_d  = '0;
    end else if (shift_i) begin
      if (frame_done) begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        sreg_d  = '0;
      end else begin
        state_d = ST_ACTIVE;
        cnt_d   = cnt_q + CNT_ONE;
        sreg_d  = sreg_shifted;
      end
    end
  end

  // Register the receive-side state. Reset discards any partial frame.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  // Output word register. It changes only when a word is loaded, so dout_o
  // keeps its value after the word has been consumed.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dout_o <= '0;
    end else if (load_word) begin
      dout_o <= word_assembled;
    end
  end

  // Valid flag. A load sets it; a transfer with no load on the same edge
  // clears it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dout_valid_o <= 1'b0;
    end else if (load_word) begin
      dout_valid_o <= 1'b1;
    end else if (transfer) begin
      dout_valid_o <= 1'b0;
    end
  end

  // Sticky overrun flag. A new drop wins over a request to clear it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overrun_o <= 1'b0;
    end else if (drop_word) begin
      overrun_o <= 1'b1;
    end else if (clear_ovr_i) begin
      overrun_o <= 1'b0;
    end
  end

`ifdef SHIFT_DESER_PARITY_EN
  // The parity error flag is loaded together with the word. A dropped word
  // leaves it unchanged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      parity_err_q <= 1'b0;
    end else if (load_word) begin
      parity_err_q <= parity_calc;
    end
  end

  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_shift_deser.sv
// tb_shift_deser: randomized and directed checks of shift_deser.
// Two instances share the same inputs: one with MSB_FIRST=1, one with
// MSB_FIRST=0. A frame-level reference model predicts their outputs.
// Honors SHIFT_DESER_PARITY_EN in the same way as the design.

module tb_shift_deser;

  localparam int W = 8;
`ifdef SHIFT_DESER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b0;
  logic         sin_i = 1'b0;
  logic         shift_i = 1'b0;
  logic         clear_i = 1'b0;
  logic         dout_ready_i = 1'b0;
  logic         clear_ovr_i = 1'b0;
  logic [W-1:0] dout_msb;
  logic [W-1:0] dout_lsb;
  logic         valid_msb;
  logic         valid_lsb;
  logic         ovr_msb;
  logic         ovr_lsb;
`ifdef SHIFT_DESER_PARITY_EN
  logic         perr_msb;
  logic         perr_lsb;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state, kept at the frame level.
  logic         frame_bits[$];
  logic [W-1:0] m_dout_msb = '0;
  logic [W-1:0] m_dout_lsb = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;
  logic         m_perr = 1'b0;

  // Free-running clock
  always #5 clk_i = ~clk_i;

  shift_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk_i), .reset_i(reset_i), .sin_i(sin_i), .shift_i(shift_i),
    .clear_i(clear_i), .dout_o(dout_msb), .dout_valid_o(valid_msb),
    .dout_ready_i(dout_ready_i), .overrun_o(ovr_msb),
`ifdef SHIFT_DESER_PARITY_EN
    .parity_err_o(perr_msb),
`endif
    .clear_ovr_i(clear_ovr_i)
  );

  shift_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk_i), .reset_i(reset_i), .sin_i(sin_i), .shift_i(shift_i),
    .clear_i(clear_i), .dout_o(dout_lsb), .dout_valid_o(valid_lsb),
    .dout_ready_i(dout_ready_i), .overrun_o(ovr_lsb),
`ifdef SHIFT_DESER_PARITY_EN
    .parity_err_o(perr_lsb),
`endif
    .clear_ovr_i(clear_ovr_i)
  );

  // Count one comparison and report it if the values differ
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the reference model by one clock edge using the current inputs
  task automatic modelStep(input logic rst, input logic sh, input logic b,
                           input logic clr, input logic rdy, input logic cov);
    logic         frame[$];
    logic [W-1:0] wm;
    logic [W-1:0] wl;
    logic         par;
    logic         done;
    logic         dropped;
    if (rst) begin
      frame_bits.delete();
      m_dout_msb = '0;
      m_dout_lsb = '0;
      m_valid    = 1'b0;
      m_ovr      = 1'b0;
      m_perr     = 1'b0;
      return;
    end
    done    = sh && !clr && (frame_bits.size() == FRAME - 1);
    dropped = 1'b0;
    wm = '0;
    wl = '0;
    par = 1'b0;
    if (done) begin
      frame = frame_bits;
      frame.push_back(b);
      for (int i = 0; i < W; i++) begin
        wm[W-1-i] = frame[i];
        wl[i]     = frame[i];
      end
      for (int i = 0; i < FRAME; i++) par ^= frame[i];
    end
    if (clr) frame_bits.delete();
    else if (sh) begin
      if (done) frame_bits.delete();
      else frame_bits.push_back(b);
    end
    if (done && (!m_valid || rdy)) begin
      m_dout_msb = wm;
      m_dout_lsb = wl;
      m_perr     = par;
      m_valid    = 1'b1;
    end else if (done) begin
      dropped = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (dropped) m_ovr = 1'b1;
    else if (cov) m_ovr = 1'b0;
  endtask

  // Drive one cycle of inputs, step the model, then compare after the edge
  task automatic applyStimulus(input logic rst, input logic sh, input logic b,
                               input logic clr, input logic rdy, input logic cov);
    @(negedge clk_i);
    reset_i      = rst;
    shift_i      = sh;
    sin_i        = b;
    clear_i      = clr;
    dout_ready_i = rdy;
    clear_ovr_i  = cov;
    modelStep(rst, sh, b, clr, rdy, cov);
    @(posedge clk_i);
    #1;
    checkOutput("dout_msb", 32'(dout_msb), 32'(m_dout_msb));
    checkOutput("dout_lsb", 32'(dout_lsb), 32'(m_dout_lsb));
    checkOutput("valid_msb", 32'(valid_msb), 32'(m_valid));
    checkOutput("valid_lsb", 32'(valid_lsb), 32'(m_valid));
    checkOutput("ovr_msb", 32'(ovr_msb), 32'(m_ovr));
    checkOutput("ovr_lsb", 32'(ovr_lsb), 32'(m_ovr));
`ifdef SHIFT_DESER_PARITY_EN
    checkOutput("perr_msb", 32'(perr_msb), 32'(m_perr));
    checkOutput("perr_lsb", 32'(perr_lsb), 32'(m_perr));
`endif
  endtask

  // Send one frame MSB first, with even parity appended if parity is enabled.
  // The final bit is driven with rdy_last; the others with rdy.
  task automatic sendFrame(input logic [W-1:0] word, input logic rdy,
                           input logic rdy_last, input logic bad_par);
    logic b;
    for (int i = 0; i < FRAME; i++) begin
      if (i < W) b = word[W-1-i];
      else b = (^word) ^ bad_par;
      applyStimulus(1'b0, 1'b1, b, 1'b0, (i == FRAME - 1) ? rdy_last : rdy, 1'b0);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_dout", 32'(dout_msb), 32'h0);
    checkOutput("reset_valid", 32'(valid_msb), 32'h0);
    checkOutput("reset_ovr", 32'(ovr_msb), 32'h0);

    // A5 received with ready high: valid for exactly one cycle
    sendFrame(8'hA5, 1'b1, 1'b1, 1'b0);
    checkOutput("a5_msb", 32'(dout_msb), 32'hA5);
    checkOutput("a5_lsb", 32'(dout_lsb), 32'hA5);
    checkOutput("a5_valid", 32'(valid_msb), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("a5_valid_drop", 32'(valid_msb), 32'h0);
    checkOutput("a5_hold", 32'(dout_msb), 32'hA5);

    // Bits 1,1,0,0,0,0,0,0 arriving LSB first give 03
    sendFrame(8'hC0, 1'b1, 1'b1, 1'b0);
    checkOutput("c0_lsb", 32'(dout_lsb), 32'h03);
    checkOutput("c0_msb", 32'(dout_msb), 32'hC0);

    // Overrun: second word is dropped while the first is held
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendFrame(8'h11, 1'b0, 1'b0, 1'b0);
    sendFrame(8'h22, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_dout", 32'(dout_msb), 32'h11);
    checkOutput("ovr_set", 32'(ovr_msb), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_clear", 32'(ovr_msb), 32'h0);

    // Partial word cleared, with shift high on the clearing edge
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    sendFrame(8'h5A, 1'b1, 1'b1, 1'b0);
    checkOutput("clr_dout", 32'(dout_msb), 32'h5A);

    // A new word completes on the same edge the held word is taken
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendFrame(8'h3C, 1'b0, 1'b0, 1'b0);
    sendFrame(8'hC3, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_dout", 32'(dout_msb), 32'hC3);
    checkOutput("b2b_valid", 32'(valid_msb), 32'h1);
    checkOutput("b2b_ovr", 32'(ovr_msb), 32'h0);

    // Reset in the middle of a word while a word is held
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("mid_rst_dout", 32'(dout_msb), 32'h0);
    checkOutput("mid_rst_valid", 32'(valid_msb), 32'h0);
    sendFrame(8'hFF, 1'b1, 1'b1, 1'b0);
    checkOutput("ff_dout", 32'(dout_msb), 32'hFF);
    checkOutput("ff_valid", 32'(valid_msb), 32'h1);
`ifdef SHIFT_DESER_PARITY_EN
    sendFrame(8'h01, 1'b1, 1'b1, 1'b1);
    checkOutput("par_err", 32'(perr_msb), 32'h1);
    sendFrame(8'h01, 1'b1, 1'b1, 1'b0);
    checkOutput("par_ok", 32'(perr_msb), 32'h0);
`endif

    // Random traffic checked cycle by cycle against the model
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 255) == 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom()),
                    ($urandom_range(0, 31) == 0),
                    1'($urandom()),
                    ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
